song_sample_player: RTL and testbench
=====================================

Name: song_sample_player

Overview:
- Upstream stage of the audio mixer top level.
- Walks the read-only song RAM (ram32x4: 8-bit address, 32-bit q) and supplies one held 32-bit sample that the mixer adds to the microphone input.
- Advances one RAM word every HOLD audio frames. Each frame is marked by sample_tick, which the top level drives from audio_in_available & audio_out_allowed.
- Supports start, stop, loop and end-of-song notification.

Parameters:
- ADDR_W, 8: RAM address width.
- DATA_W, 32: sample width.
- LAST_ADDR, 255: final song word address; playback covers 0..LAST_ADDR inclusive.
- HOLD, 1: audio frames (sample_tick pulses) per RAM word; legal range ≥1.
- RD_LAT, 1: RAM read latency in cycles, from an address change to valid q; legal range ≥1.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin or restart playback at address 0.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  level; when high, wrap from LAST_ADDR to 0 instead of finishing.
- sample_tick  in  1  one-cycle pulse per audio frame.
- mem_address  out  ADDR_W  RAM read address (wren is tied low at the top level).
- mem_q  in  DATA_W  RAM read data.
- sample_out  out  DATA_W  current song sample, two's complement.
- sample_valid  out  1  high while sample_out holds a fetched word.
- playing  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:

Reset (asynchronous assert):
- mem_address=0, sample_out=0, sample_valid=0, playing=0, done=0.
- State=IDLE, hold_cnt=0, lat_cnt=0, pending=0.

States:
- IDLE: sample_out=0, sample_valid=0. start -> FETCH with mem_address=0 and lat_cnt cleared.
- FETCH:
  - Wait RD_LAT cycles after the address update.
  - On the cycle lat_cnt==RD_LAT-1, register mem_q into sample_out, set sample_valid=1, go to PLAY.
  - sample_out keeps the previous word during FETCH, so no zero glitch between words.
- PLAY:
  - Each sample_tick (or a pending tick, consumed on the first PLAY cycle) increments hold_cnt.
  - On a tick with hold_cnt==HOLD-1: clear hold_cnt.
    - If mem_address<LAST_ADDR: mem_address+1, go to FETCH.
    - If mem_address==LAST_ADDR and loop_en=1: mem_address=0, go to FETCH.
    - If mem_address==LAST_ADDR and loop_en=0: pulse done for 1 cycle, go to IDLE, sample_out=0, sample_valid=0, mem_address=0.

Ticks during FETCH:
- A sample_tick in FETCH sets pending. pending saturates at 1; extra ticks are dropped.
- pending is cleared when consumed.

Control priority, evaluated each cycle in this order:
1. reset.
2. stop: in any state go to IDLE with IDLE outputs, hold_cnt=0, pending=0. No done pulse.
3. start: in any state restart at FETCH with address 0, hold_cnt=0, pending=0. sample_out keeps its last value until the first fetch lands.
4. Normal FSM operation.

Simultaneous events:
- start and stop in the same cycle: stop wins.
- start in the same cycle as end-of-song: start wins and no done pulse is produced.

Outputs and arithmetic:
- playing = (state != IDLE).
- mem_address is registered. Its wrap is explicit (LAST_ADDR -> 0), never by overflow.
- hold_cnt width is $clog2(HOLD)+1.
- sample_out is a registered copy of mem_q; no arithmetic is applied in the base build.

Optional Feature:
Macro SONG_VOLUME_EN.
- Defined:
  - Adds input port volume (3 bits).
  - sample_out = mem_q arithmetically right-shifted by volume, with sign preserved, registered at the FETCH capture point.
  - volume is sampled at each capture, so a change takes effect from the next word.
  - volume=0 gives an unshifted sample.
- Not defined: no volume port; sample_out = mem_q.

Test Plan:
1. Reset release, start pulse, RAM model with q=addr*16, RD_LAT=1, HOLD=1:
   - mem_address=0, and sample_out=0 registered 1 cycle later with sample_valid=1.
   - Each tick advances: tick 1 gives addr 1, sample 16; tick 2 gives addr 2, sample 32.
2. LAST_ADDR=3, loop_en=0, ticks to the end:
   - After the 4th tick, done pulses exactly 1 cycle; playing=0, sample_out=0, mem_address=0.
   - Further ticks cause no activity.
3. LAST_ADDR=3, loop_en=1:
   - Address sequence 0,1,2,3,0,1 across 5 ticks; done never asserts.
4. HOLD=3:
   - mem_address changes only on every 3rd tick.
   - A tick injected during FETCH (RD_LAT=2) is counted via pending, with no lost or double count.
5. stop mid-song at addr 5:
   - Next cycle: IDLE, sample_out=0, no done.
   - start and stop in the same cycle leaves the block IDLE.
   - Asynchronous reset asserted mid-FETCH clears all outputs immediately, without waiting for a clock edge.
6. SONG_VOLUME_EN, q=-32'sd1024, volume=2:
   - sample_out=-256.
   - Changing volume mid-word leaves the current sample unchanged until the next fetch.

Source files
------------

// File: rtl/song_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : song_sample_player
// Purpose  : Walks a read-only song RAM and presents one held sample word to
//            the audio mixer. One RAM word is played for HOLD audio frames
//            (sample_tick pulses); supports start, stop, loop and an
//            end-of-song done pulse.
// Ports    : CLOCK_50     - system clock, rising edge
//            reset        - asynchronous active-high reset
//            start/stop   - one-cycle control pulses (stop has priority)
//            loop_en      - wrap from LAST_ADDR to 0 instead of finishing
//            sample_tick  - one pulse per audio frame
//            mem_address  - RAM read address (registered)
//            mem_q        - RAM read data, valid RD_LAT cycles after address
//            sample_out   - current song sample (two's complement)
//            sample_valid - sample_out holds a fetched word
//            playing      - block is not idle
//            done         - one-cycle pulse when a non-looping song ends
//            volume       - (SONG_VOLUME_EN only) arithmetic right shift
// Options  : define SONG_VOLUME_EN to add the 3-bit volume input.
// Revision : 1.0 - initial release
// ============================================================================
module song_sample_player #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int LAST_ADDR = 255,
  parameter int HOLD      = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              sample_tick,
`ifdef SONG_VOLUME_EN
  input  logic [2:0]        volume,
`endif
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              playing,
  output logic              done
);

  localparam int HOLD_W = $clog2(HOLD) + 1;
  localparam int LAT_W  = $clog2(RD_LAT) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic                pending;
  logic [DATA_W-1:0]   capture_word;

  // Word loaded into sample_out at the end of a fetch.
`ifdef SONG_VOLUME_EN
  assign capture_word = $signed(mem_q) >>> volume;
`else
  assign capture_word = mem_q;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mem_address  <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
      hold_cnt     <= '0;
      lat_cnt      <= '0;
      pending      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        playing      <= 1'b0;
        mem_address  <= '0;
        sample_out   <= '0;
        sample_valid <= 1'b0;
        hold_cnt     <= '0;
        lat_cnt      <= '0;
        pending      <= 1'b0;
      end else if (start) begin
        // Restart keeps the previous sample on the output until the first
        // word of the new pass lands, avoiding a gap at the mixer.
        state       <= FETCH;
        playing     <= 1'b1;
        mem_address <= '0;
        hold_cnt    <= '0;
        lat_cnt     <= '0;
        pending     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          FETCH: begin
            // A frame arriving while the RAM is busy is remembered (once).
            if (sample_tick) begin
              pending <= 1'b1;
            end
            if (lat_cnt == LAT_LAST) begin
              sample_out   <= capture_word;
              sample_valid <= 1'b1;
              lat_cnt      <= '0;
              state        <= PLAY;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (sample_tick || pending) begin
              // When a remembered frame and a fresh one coincide, one is
              // consumed now and the other stays remembered.
              pending <= sample_tick && pending;
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                if (mem_address < END_ADDR) begin
                  mem_address <= mem_address + 1'b1;
                  state       <= FETCH;
                end else if (loop_en) begin
                  mem_address <= '0;
                  state       <= FETCH;
                end else begin
                  state        <= IDLE;
                  playing      <= 1'b0;
                  done         <= 1'b1;
                  mem_address  <= '0;
                  sample_out   <= '0;
                  sample_valid <= 1'b0;
                end
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_song_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_song_sample_player
// Purpose  : Self-checking bench for song_sample_player. Two instances share
//            the same control stimulus: A (LAST_ADDR=3, HOLD=1, RD_LAT=1) and
//            B (LAST_ADDR=7, HOLD=3, RD_LAT=2). Each is compared every cycle
//            against a frame/word-level reference model, plus directed checks.
// Options  : define SONG_VOLUME_EN to exercise the volume input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_song_sample_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, stop, loop_en, tick;
`ifdef SONG_VOLUME_EN
  logic [2:0] vol;
`endif

  logic [7:0]  addr_o  [2];
  logic [31:0] smp_o   [2];
  logic        valid_o [2];
  logic        play_o  [2];
  logic        done_o  [2];

  logic [31:0] ram [256];
  logic [31:0] q_a, q_b;
  logic [7:0]  addr_b_d;

  // RAM models: A answers in the same cycle the address is presented
  // (one-cycle latency to capture), B adds one extra register stage.
  assign q_a = ram[addr_o[0]];
  always @(posedge clk) addr_b_d <= addr_o[1];
  assign q_b = ram[addr_b_d];

  song_sample_player #(.ADDR_W(8), .DATA_W(32), .LAST_ADDR(3), .HOLD(1), .RD_LAT(1)) u_a (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .sample_tick(tick),
`ifdef SONG_VOLUME_EN
    .volume(vol),
`endif
    .mem_address(addr_o[0]), .mem_q(q_a), .sample_out(smp_o[0]),
    .sample_valid(valid_o[0]), .playing(play_o[0]), .done(done_o[0]));

  song_sample_player #(.ADDR_W(8), .DATA_W(32), .LAST_ADDR(7), .HOLD(3), .RD_LAT(2)) u_b (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .sample_tick(tick),
`ifdef SONG_VOLUME_EN
    .volume(vol),
`endif
    .mem_address(addr_o[1]), .mem_q(q_b), .sample_out(smp_o[1]),
    .sample_valid(valid_o[1]), .playing(play_o[1]), .done(done_o[1]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int p_last(input int k); return (k == 0) ? 3 : 7; endfunction
  function automatic int p_hold(input int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int p_lat (input int k); return (k == 0) ? 1 : 2; endfunction

  bit          m_act   [2];
  int          m_wait  [2];  // fetch cycles still to go; 0 means playing
  int          m_addr  [2];
  logic [31:0] m_smp   [2];
  bit          m_valid [2];
  bit          m_done  [2];
  int          m_frames[2];  // frames already spent on the current word
  int          m_owed  [2];  // frames heard while fetching, not yet spent

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_wait[k] = 0; m_addr[k] = 0; m_smp[k] = '0;
      m_valid[k] = 0; m_done[k] = 0; m_frames[k] = 0; m_owed[k] = 0;
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
`ifdef SONG_VOLUME_EN
    return $signed(ram[a]) >>> vol;
`else
    return ram[a];
`endif
  endfunction

  task automatic model_step(input int k);
    int n;
    m_done[k] = 0;
    if (stop) begin
      m_act[k] = 0; m_wait[k] = 0; m_addr[k] = 0; m_smp[k] = '0;
      m_valid[k] = 0; m_frames[k] = 0; m_owed[k] = 0;
    end else if (start) begin
      m_act[k] = 1; m_wait[k] = p_lat(k); m_addr[k] = 0;
      m_frames[k] = 0; m_owed[k] = 0;
    end else if (m_act[k] && m_wait[k] > 0) begin
      if (tick) m_owed[k] = 1;
      if (m_wait[k] == 1) begin
        m_smp[k] = word_at(m_addr[k]);
        m_valid[k] = 1;
      end
      m_wait[k]--;
    end else if (m_act[k]) begin
      n = m_owed[k] + (tick ? 1 : 0);
      if (n > 0) begin
        m_owed[k] = n - 1;
        m_frames[k]++;
        if (m_frames[k] == p_hold(k)) begin
          m_frames[k] = 0;
          if (m_addr[k] < p_last(k)) begin
            m_addr[k]++; m_wait[k] = p_lat(k);
          end else if (loop_en) begin
            m_addr[k] = 0; m_wait[k] = p_lat(k);
          end else begin
            m_act[k] = 0; m_done[k] = 1; m_addr[k] = 0;
            m_smp[k] = '0; m_valid[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare(input int k);
    string n;
    n = (k == 0) ? "A" : "B";
    check({n, ".addr"},    32'(addr_o[k]),  32'(m_addr[k]));
    check({n, ".sample"},  smp_o[k],        m_smp[k]);
    check({n, ".valid"},   32'(valid_o[k]), 32'(m_valid[k]));
    check({n, ".playing"}, 32'(play_o[k]),  32'(m_act[k]));
    check({n, ".done"},    32'(done_o[k]),  32'(m_done[k]));
  endtask

  bit seen_done_a;

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset();
      else model_step(k);
    end
    #1;
    if (done_o[0]) seen_done_a = 1;
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_tick(input int gap);
    tick = 1; cycle(); tick = 0; idle_n(gap);
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a_seq [5];
    int guard;
    for (int i = 0; i < 256; i++) ram[i] = 32'(i * 16);
    reset = 1; start = 0; stop = 0; loop_en = 0; tick = 0;
`ifdef SONG_VOLUME_EN
    vol = 0;
`endif
    model_reset();
    idle_n(2);
    check("rst.playing", 32'(play_o[0]), 0);
    check("rst.sample",  smp_o[1], 0);
    reset = 0;
    idle_n(2);

    // First fetch and per-tick advance (A: HOLD=1, RD_LAT=1)
    pulse_start();
    check("t1.addr0",  32'(addr_o[0]), 0);
    check("t1.valid0", 32'(valid_o[0]), 0);
    cycle();
    check("t1.smp0",   smp_o[0], 0);
    check("t1.valid1", 32'(valid_o[0]), 1);
    tick = 1; cycle(); tick = 0;
    check("t1.addr1",  32'(addr_o[0]), 1);
    cycle();
    check("t1.smp16",  smp_o[0], 32'd16);
    tick = 1; cycle(); tick = 0;
    check("t1.addr2",  32'(addr_o[0]), 2);
    cycle();
    check("t1.smp32",  smp_o[0], 32'd32);

    // End of song without loop on A
    pulse_start(); idle_n(3);
    pulse_tick(3); pulse_tick(3); pulse_tick(3);
    tick = 1; cycle(); tick = 0;
    check("t2.done",    32'(done_o[0]), 1);
    check("t2.playing", 32'(play_o[0]), 0);
    check("t2.sample",  smp_o[0], 0);
    check("t2.addr",    32'(addr_o[0]), 0);
    cycle();
    check("t2.done_one", 32'(done_o[0]), 0);
    pulse_tick(3); pulse_tick(3);
    check("t2.quiet", 32'(play_o[0]), 0);

    // Looping on A
    loop_en = 1; seen_done_a = 0;
    pulse_start(); idle_n(3);
    for (int i = 0; i < 5; i++) begin
      tick = 1; cycle(); tick = 0;
      a_seq[i] = 32'(addr_o[0]);
      idle_n(3);
    end
    check("t3.seq0", 32'(a_seq[0]), 1);
    check("t3.seq2", 32'(a_seq[2]), 3);
    check("t3.seq3", 32'(a_seq[3]), 0);
    check("t3.seq4", 32'(a_seq[4]), 1);
    check("t3.nodone", 32'(seen_done_a), 0);

    // HOLD=3 with a tick landing in B's fetch window
    pulse_start();
    tick = 1; cycle(); tick = 0;   // B still fetching: remembered
    idle_n(3);
    pulse_tick(3);
    check("t4.hold", 32'(addr_o[1]), 0);
    pulse_tick(3);
    check("t4.adv",  32'(addr_o[1]), 1);

    // Stop mid-song at B address 5
    guard = 0;
    while (addr_o[1] != 8'd5 && guard < 40) begin
      pulse_tick(3);
      guard++;
    end
    check("t5.reach5", 32'(addr_o[1]), 5);
    stop = 1; cycle(); stop = 0;
    check("t5.playing", 32'(play_o[1]), 0);
    check("t5.sample",  smp_o[1], 0);
    check("t5.done",    32'(done_o[1]), 0);
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    check("t5.ss_idle", 32'(play_o[0]), 0);

    // Asynchronous reset in the middle of a fetch
    pulse_start();
    #3 reset = 1;
    #1;
    check("t5.arst_play",  32'(play_o[1]), 0);
    check("t5.arst_valid", 32'(valid_o[0]), 0);
    check("t5.arst_smp",   smp_o[0], 0);
    model_reset();
    cycle();
    reset = 0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    loop_en = 0;
    for (int i = 0; i < 5000; i++) begin
      start = ($urandom_range(0, 199) == 0) ||
              (!m_act[0] && !m_act[1] && $urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      tick  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) loop_en = ~loop_en;
`ifdef SONG_VOLUME_EN
      if ($urandom_range(0, 49) == 0) vol = 3'($urandom_range(0, 7));
`endif
      cycle();
    end
    start = 0; stop = 0; tick = 0;

`ifdef SONG_VOLUME_EN
    // Volume shift and capture-time sampling
    stop = 1; cycle(); stop = 0;
    ram[0] = -32'sd1024;
    vol = 2;
    pulse_start(); idle_n(3);
    check("t6.shift", smp_o[0], 32'hFFFF_FF00);
    vol = 0; idle_n(3);
    check("t6.hold_vol", smp_o[0], 32'hFFFF_FF00);
    pulse_tick(3);
    check("t6.next", smp_o[0], ram[1]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
